// File: rtl/wb_pkg.sv
// Shared types and widths for the pipelined Wishbone RAM responder.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [WB_DATA_W-1:0] data;
  } wb_resp_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response delay line; 'landing' flags the response that becomes
// visible on the output after the next edge.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk,
  input  logic     clear,
  input  wb_resp_t din,
  output wb_resp_t dout,
  output logic     landing
);

  wb_resp_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign landing = din.valid;
    end else begin : g_staged
      assign landing = stage[LATENCY-2].valid;
    end
  endgenerate

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/wb_pipelined_ram.sv
// Pipelined Wishbone B4 responder over a word-addressed RAM.
// Define WB_RAM_ERR_EN to add wb_err_o and reject out-of-range addresses.
module wb_pipelined_ram
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter string       INIT_FILE       = ""
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_stall_o,
`ifdef WB_RAM_ERR_EN
  output logic                 wb_err_o,
`endif
  input  logic                 stall_request_i
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [WB_DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]     outstanding;
  logic [ADDR_W-1:0]    word;
  logic                 accept;
  logic                 addr_err;
  logic                 pipe_clear;
  logic                 landing;
  wb_resp_t             req_resp;
  wb_resp_t             out_resp;

  assign word       = wb_adr_i[ADDR_W-1:0];
  assign wb_stall_o = stall_request_i | (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign pipe_clear = rst_i | ~wb_cyc_i;

`ifdef WB_RAM_ERR_EN
  localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_W) - 32'd1);
  assign addr_err = |(wb_adr_i & HI_MASK);
`else
  logic unused_hi_adr;
  assign unused_hi_adr = ^wb_adr_i[31:ADDR_W];
  assign addr_err      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && !addr_err) begin
      for (int unsigned b = 0; b < WB_SEL_W; b++) begin
        if (wb_sel_i[b]) mem[word][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // RAM is read combinationally in the accept cycle, before that edge's write lands.
  always_comb begin
    req_resp = '0;
    if (accept) begin
      req_resp.valid = 1'b1;
      req_resp.err   = addr_err;
      if (!wb_we_i && !addr_err) req_resp.data = mem[word];
    end
  end

  wb_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk     (clk_i),
    .clear   (pipe_clear),
    .din     (req_resp),
    .dout    (out_resp),
    .landing (landing)
  );

  // A request stops counting as it lands in the output stage, so
  // MAX_OUTSTANDING >= LATENCY sustains one accept per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_cyc_i) begin
      outstanding <= '0;
    end else if (accept && !landing) begin
      outstanding <= outstanding + 1'b1;
    end else if (!accept && landing && outstanding != '0) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  assign wb_ack_o = out_resp.valid & ~out_resp.err;
  assign wb_dat_o = wb_ack_o ? out_resp.data : '0;
`ifdef WB_RAM_ERR_EN
  assign wb_err_o = out_resp.valid & out_resp.err;
`endif

endmodule
